// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU opcodes, instruction encodings and the decoded control bundle
package id_ex_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_NOT = 4'b0010, ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0100, ALU_AND = 4'b0101, ALU_OR  = 4'b0110, ALU_SLT = 4'b0111,
    ALU_ILL = 4'b1111
  } alu_op_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_NOT = 6'b100111;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  typedef struct packed {
    alu_op_e alu;
    logic    use_imm;
    logic    sext;
    logic    shift_rt;
    logic    rt_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    illegal;
  } dec_t;
endpackage

// File: rtl/id_ex_stage_decode.sv
// id_ex_stage_decode: opcode/funct -> ALU op, immediate extension, destination and control bits
module id_ex_stage_decode
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW = 5
) (
  input  logic [5:0]            opcode_i,
  input  logic [5:0]            funct_i,
  input  logic [15:0]           imm_i,
  input  logic [REG_AW-1:0]     rt_addr_i,
  input  logic [REG_AW-1:0]     rd_addr_i,
  output dec_t                  dec_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [REG_AW-1:0]     dest_o
);
  dec_t d;
  always_comb begin
    d = '0;
    d.alu = ALU_ILL;
    if (opcode_i == OP_RTYPE) begin
      d.rt_src = 1'b1;
      d.reg_write = 1'b1;
      case (funct_i)
        F_ADD: d.alu = ALU_ADD;
        F_SUB: d.alu = ALU_SUB;
        F_NOT: d.alu = ALU_NOT;
        F_SLL: begin d.alu = ALU_SLL; d.shift_rt = 1'b1; end
        F_SRL: begin d.alu = ALU_SRL; d.shift_rt = 1'b1; end
        F_AND: d.alu = ALU_AND;
        F_OR:  d.alu = ALU_OR;
        F_SLT: d.alu = ALU_SLT;
        default: begin d.illegal = 1'b1; d.reg_write = 1'b0; end
      endcase
    end else begin
      d.use_imm = 1'b1;
      d.sext = 1'b1;
      d.reg_write = 1'b1;
      case (opcode_i)
        OP_ADDI: d.alu = ALU_ADD;
        OP_SLTI: d.alu = ALU_SLT;
        OP_ANDI: begin d.alu = ALU_AND; d.sext = 1'b0; end
        OP_ORI:  begin d.alu = ALU_OR; d.sext = 1'b0; end
        OP_LW:   begin d.alu = ALU_ADD; d.mem_read = 1'b1; end
        OP_SW:   begin d.alu = ALU_ADD; d.mem_write = 1'b1; d.reg_write = 1'b0; d.rt_src = 1'b1; end
        // beq compares rs against rt, so the immediate is not an ALU operand
        OP_BEQ:  begin d.alu = ALU_SUB; d.use_imm = 1'b0; d.reg_write = 1'b0; d.rt_src = 1'b1; end
        default: begin d.illegal = 1'b1; d.use_imm = 1'b0; d.reg_write = 1'b0; end
      endcase
    end
    if (dest_o == '0) d.reg_write = 1'b0;
  end
  assign dest_o = (opcode_i == OP_RTYPE) ? rd_addr_i : rt_addr_i;
  assign imm_o = d.sext ? {{(DATA_WIDTH-16){imm_i[15]}}, imm_i} : {{(DATA_WIDTH-16){1'b0}}, imm_i};
  assign dec_o = d;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding, load-use detection and bubbles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW = 5,
  parameter int FORWARD_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [4:0]            shamt,
  input  logic [15:0]           immediate,
  input  logic [REG_AW-1:0]     rsAddr,
  input  logic [REG_AW-1:0]     rtAddr,
  input  logic [REG_AW-1:0]     rdAddr,
  input  logic [DATA_WIDTH-1:0] rsData,
  input  logic [DATA_WIDTH-1:0] rtData,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exMemRegWrite,
  input  logic                  memWbRegWrite,
  input  logic [REG_AW-1:0]     exMemRd,
  input  logic [REG_AW-1:0]     memWbRd,
  input  logic [DATA_WIDTH-1:0] exMemResult,
  input  logic [DATA_WIDTH-1:0] memWbResult,
  output logic                  outValid,
  output logic [DATA_WIDTH-1:0] inputOne,
  output logic [DATA_WIDTH-1:0] inputTwo,
  output logic [3:0]            ALUControl,
  output logic [4:0]            shiftAmount,
  output logic [REG_AW-1:0]     destReg,
  output logic                  regWrite,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [DATA_WIDTH-1:0] storeData,
  output logic                  illegalOp
);
  dec_t                  dec;
  logic [DATA_WIDTH-1:0] imm_ext, rs_fwd, rt_fwd;
  logic [REG_AW-1:0]     dest_d;
  logic                  load_use;
  logic                  valid_q, rw_q, mr_q, mw_q, ill_q;
  logic [DATA_WIDTH-1:0] one_q, two_q, store_q;
  logic [3:0]            alu_q;
  logic [4:0]            shamt_q;
  logic [REG_AW-1:0]     dest_q;
  id_ex_stage_decode #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_dec (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .imm_i     (immediate),
    .rt_addr_i (rtAddr),
    .rd_addr_i (rdAddr),
    .dec_o     (dec),
    .imm_o     (imm_ext),
    .dest_o    (dest_d)
  );
  // register 0 reads as zero and is never a forwarding target
  assign rs_fwd = (rsAddr == '0) ? '0 :
                  (FORWARD_EN != 0 && exMemRegWrite && exMemRd == rsAddr) ? exMemResult :
                  (FORWARD_EN != 0 && memWbRegWrite && memWbRd == rsAddr) ? memWbResult : rsData;
  assign rt_fwd = (rtAddr == '0) ? '0 :
                  (FORWARD_EN != 0 && exMemRegWrite && exMemRd == rtAddr) ? exMemResult :
                  (FORWARD_EN != 0 && memWbRegWrite && memWbRd == rtAddr) ? memWbResult : rtData;
  assign load_use = valid_q && mr_q && dest_q != '0 && inValid &&
                    (dest_q == rsAddr || (dest_q == rtAddr && dec.rt_src));
  assign inReady = !stall && !load_use;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      one_q   <= '0;
      two_q   <= '0;
      alu_q   <= ALU_ADD;
      shamt_q <= '0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      store_q <= '0;
      ill_q   <= 1'b0;
    end else if (flush || (!stall && (load_use || !inValid))) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= 1'b1;
      one_q   <= dec.shift_rt ? rt_fwd : rs_fwd;
      two_q   <= dec.use_imm ? imm_ext : rt_fwd;
      alu_q   <= dec.alu;
      shamt_q <= (opcode == OP_RTYPE) ? shamt : '0;
      dest_q  <= dest_d;
      rw_q    <= dec.reg_write;
      mr_q    <= dec.mem_read;
      mw_q    <= dec.mem_write;
      store_q <= rt_fwd;
      ill_q   <= dec.illegal;
    end
  end
  assign outValid    = valid_q;
  assign inputOne    = one_q;
  assign inputTwo    = two_q;
  assign ALUControl  = alu_q;
  assign shiftAmount = shamt_q;
  assign destReg     = dest_q;
  assign regWrite    = rw_q;
  assign memRead     = mr_q;
  assign memWrite    = mw_q;
  assign storeData   = store_q;
  assign illegalOp   = ill_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table vectors, hazard sequences and random stimulus against a reference model
module tb_id_ex_stage;
  typedef struct {
    logic iv; logic [5:0] op, fn; logic [4:0] sh; logic [15:0] imm;
    logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd;
    logic stall, flush, exw, mww; logic [4:0] exrd, mwrd; logic [31:0] exres, mwres;
  } in_t;
  typedef struct {
    logic v; logic [31:0] one, two; logic [3:0] alu; logic [4:0] sa, dest;
    logic rw, mr, mw; logic [31:0] sd; logic ill;
  } st_t;
  typedef struct {
    in_t x; logic [31:0] one, two; logic [3:0] alu; logic [4:0] dest; logic rw, ill;
  } vec_t;

  logic clk = 0, rst = 1, inValid = 0, stall = 0, flush = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic [4:0] shamt = 0, rsAddr = 0, rtAddr = 0, rdAddr = 0, exMemRd = 0, memWbRd = 0;
  logic [15:0] immediate = 0;
  logic [31:0] rsData = 0, rtData = 0, exMemResult = 0, memWbResult = 0;
  logic exMemRegWrite = 0, memWbRegWrite = 0;
  logic inReady, outValid, regWrite, memRead, memWrite, illegalOp;
  logic [31:0] inputOne, inputTwo, storeData;
  logic [3:0] ALUControl;
  logic [4:0] shiftAmount, destReg;
  int total = 0, passed = 0;
  logic rdy_seen;
  st_t m;
  vec_t tbl[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .opcode(opcode), .funct(funct),
    .shamt(shamt), .immediate(immediate), .rsAddr(rsAddr), .rtAddr(rtAddr), .rdAddr(rdAddr),
    .rsData(rsData), .rtData(rtData), .stall(stall), .flush(flush),
    .exMemRegWrite(exMemRegWrite), .memWbRegWrite(memWbRegWrite), .exMemRd(exMemRd),
    .memWbRd(memWbRd), .exMemResult(exMemResult), .memWbResult(memWbResult),
    .outValid(outValid), .inputOne(inputOne), .inputTwo(inputTwo), .ALUControl(ALUControl),
    .shiftAmount(shiftAmount), .destReg(destReg), .regWrite(regWrite), .memRead(memRead),
    .memWrite(memWrite), .storeData(storeData), .illegalOp(illegalOp)
  );

  function automatic in_t mk(logic [5:0] op, fn, logic [4:0] sh, logic [15:0] imm,
                             logic [4:0] rs, rt, rd, logic [31:0] rsd, rtd);
    in_t x = '{default: '0};
    x.iv = 1; x.op = op; x.fn = fn; x.sh = sh; x.imm = imm;
    x.rs = rs; x.rt = rt; x.rd = rd; x.rsd = rsd; x.rtd = rtd;
    return x;
  endfunction

  function automatic in_t fw(in_t x, logic exw, logic [4:0] exrd, logic [31:0] exres,
                             logic mww, logic [4:0] mwrd, logic [31:0] mwres);
    x.exw = exw; x.exrd = exrd; x.exres = exres; x.mww = mww; x.mwrd = mwrd; x.mwres = mwres;
    return x;
  endfunction

  // Reference: what the register holds after one edge, derived from the instruction-set rules
  function automatic logic lus(st_t s, in_t x);
    logic rt_used = (x.op == 6'h00) || (x.op == 6'h2b) || (x.op == 6'h04);
    return s.v && s.mr && s.dest != 0 && x.iv && (s.dest == x.rs || (s.dest == x.rt && rt_used));
  endfunction

  function automatic logic [31:0] src(in_t x, logic [4:0] a, logic [31:0] raw);
    if (a == 0) return 0;
    if (x.exw && x.exrd == a) return x.exres;
    if (x.mww && x.mwrd == a) return x.mwres;
    return raw;
  endfunction

  function automatic st_t step(st_t s, in_t x);
    st_t n = s;
    logic [31:0] a, b, sx, zx;
    if (x.flush || (!x.stall && (!x.iv || lus(s, x)))) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.ill = 0;
      return n;
    end
    if (x.stall) return n;
    a = src(x, x.rs, x.rsd);
    b = src(x, x.rt, x.rtd);
    sx = {{16{x.imm[15]}}, x.imm};
    zx = {16'h0, x.imm};
    n.v = 1; n.one = a; n.two = b; n.sd = b; n.mr = 0; n.mw = 0; n.ill = 0; n.sa = 0; n.rw = 1;
    if (x.op == 0) begin
      n.dest = x.rd; n.sa = x.sh;
      case (x.fn)
        6'h20: n.alu = 0;
        6'h22: n.alu = 1;
        6'h27: n.alu = 2;
        6'h00: begin n.alu = 3; n.one = b; end
        6'h02: begin n.alu = 4; n.one = b; end
        6'h24: n.alu = 5;
        6'h25: n.alu = 6;
        6'h2a: n.alu = 7;
        default: begin n.alu = 15; n.ill = 1; n.rw = 0; end
      endcase
    end else begin
      n.dest = x.rt;
      case (x.op)
        6'h08: begin n.alu = 0; n.two = sx; end
        6'h0a: begin n.alu = 7; n.two = sx; end
        6'h0c: begin n.alu = 5; n.two = zx; end
        6'h0d: begin n.alu = 6; n.two = zx; end
        6'h23: begin n.alu = 0; n.two = sx; n.mr = 1; end
        6'h2b: begin n.alu = 0; n.two = sx; n.mw = 1; n.rw = 0; end
        6'h04: begin n.alu = 1; n.rw = 0; end
        default: begin n.alu = 15; n.ill = 1; n.rw = 0; end
      endcase
    end
    if (n.dest == 0) n.rw = 0;
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(in_t x);
    inValid = x.iv; opcode = x.op; funct = x.fn; shamt = x.sh; immediate = x.imm;
    rsAddr = x.rs; rtAddr = x.rt; rdAddr = x.rd; rsData = x.rsd; rtData = x.rtd;
    stall = x.stall; flush = x.flush; exMemRegWrite = x.exw; memWbRegWrite = x.mww;
    exMemRd = x.exrd; memWbRd = x.mwrd; exMemResult = x.exres; memWbResult = x.mwres;
  endtask

  task automatic cmp(string t, st_t e);
    chk({t, ".outValid"}, outValid, e.v);
    chk({t, ".inputOne"}, inputOne, e.one);
    chk({t, ".inputTwo"}, inputTwo, e.two);
    chk({t, ".ALUControl"}, ALUControl, e.alu);
    chk({t, ".shiftAmount"}, shiftAmount, e.sa);
    chk({t, ".destReg"}, destReg, e.dest);
    chk({t, ".regWrite"}, regWrite, e.rw);
    chk({t, ".memRead"}, memRead, e.mr);
    chk({t, ".memWrite"}, memWrite, e.mw);
    chk({t, ".storeData"}, storeData, e.sd);
    chk({t, ".illegalOp"}, illegalOp, e.ill);
  endtask

  task automatic cyc(string t, in_t x);
    st_t e;
    @(negedge clk);
    drive(x);
    #1;
    rdy_seen = inReady;
    chk({t, ".inReady"}, inReady, !x.stall && !lus(m, x));
    e = step(m, x);
    @(posedge clk);
    #1;
    cmp(t, e);
    m = e;
  endtask

  initial begin
    in_t x;
    m = '{default: '0};
    // reset held two cycles while ID presents a valid instruction
    rst = 1;
    drive(mk(6'h00, 6'h20, 0, 0, 3, 4, 8, 5, 7));
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", m);
    @(negedge clk);
    rst = 0;
    inValid = 0;
    #1;
    chk("reset.inReady", inReady, 1);

    tbl.push_back('{mk(6'h00, 6'h20, 0, 16'h0, 3, 4, 8, 5, 7), 5, 7, 4'h0, 8, 1, 0});
    tbl.push_back('{mk(6'h08, 6'h00, 0, 16'hFFFF, 1, 2, 0, 10, 0), 10, 32'hFFFFFFFF, 4'h0, 2, 1, 0});
    tbl.push_back('{mk(6'h0d, 6'h00, 0, 16'hFFFF, 1, 2, 0, 10, 0), 10, 32'h0000FFFF, 4'h6, 2, 1, 0});
    tbl.push_back('{fw(mk(6'h00, 6'h20, 0, 0, 5, 6, 9, 1, 2), 1, 5, 11, 1, 5, 22), 11, 2, 4'h0, 9, 1, 0});
    tbl.push_back('{fw(mk(6'h00, 6'h20, 0, 0, 0, 6, 9, 99, 2), 1, 0, 33, 0, 0, 0), 0, 2, 4'h0, 9, 1, 0});
    tbl.push_back('{fw(mk(6'h00, 6'h20, 0, 0, 1, 7, 3, 1, 0), 0, 0, 0, 1, 7, 44), 1, 44, 4'h0, 3, 1, 0});
    tbl.push_back('{mk(6'h00, 6'h00, 3, 0, 3, 4, 8, 5, 7), 7, 7, 4'h3, 8, 1, 0});
    tbl.push_back('{mk(6'h00, 6'h3f, 0, 0, 3, 4, 8, 5, 7), 5, 7, 4'hF, 8, 0, 1});
    tbl.push_back('{mk(6'h2b, 6'h00, 0, 16'h0004, 1, 2, 0, 100, 55), 100, 4, 4'h0, 2, 0, 0});
    tbl.push_back('{mk(6'h04, 6'h00, 0, 16'h0010, 1, 2, 0, 3, 3), 3, 3, 4'h1, 2, 0, 0});
    tbl.push_back('{mk(6'h00, 6'h22, 0, 0, 3, 4, 0, 9, 4), 9, 4, 4'h1, 0, 0, 0});
    tbl.push_back('{mk(6'h0a, 6'h00, 0, 16'h8000, 1, 2, 0, 1, 0), 1, 32'hFFFF8000, 4'h7, 2, 1, 0});
    tbl.push_back('{mk(6'h3f, 6'h00, 0, 16'h1234, 1, 2, 0, 1, 0), 1, 0, 4'hF, 2, 0, 1});
    foreach (tbl[k]) begin
      cyc($sformatf("tbl%0d", k), tbl[k].x);
      chk($sformatf("tbl%0d.one", k), inputOne, tbl[k].one);
      chk($sformatf("tbl%0d.two", k), inputTwo, tbl[k].two);
      chk($sformatf("tbl%0d.alu", k), ALUControl, tbl[k].alu);
      chk($sformatf("tbl%0d.dest", k), destReg, tbl[k].dest);
      chk($sformatf("tbl%0d.rw", k), regWrite, tbl[k].rw);
      chk($sformatf("tbl%0d.ill", k), illegalOp, tbl[k].ill);
    end

    // load-use: lw writing r6 followed by add reading r6
    cyc("lw", mk(6'h23, 0, 0, 16'h0, 1, 6, 0, 200, 0));
    cyc("lu", mk(6'h00, 6'h20, 0, 0, 6, 4, 8, 0, 7));
    chk("lu.inReady_low", rdy_seen, 0);
    chk("lu.bubble", outValid, 0);
    cyc("lu_retry", mk(6'h00, 6'h20, 0, 0, 6, 4, 8, 77, 7));
    chk("lu_retry.one", inputOne, 77);

    // stall alone holds everything, flush beats stall
    cyc("pre_stall", mk(6'h00, 6'h25, 0, 0, 3, 4, 8, 32'hF0, 32'h0F));
    x = mk(6'h08, 0, 0, 16'h1, 1, 2, 0, 1, 1);
    x.stall = 1;
    cyc("stall", x);
    chk("stall.hold_one", inputOne, 32'hF0);
    chk("stall.hold_alu", ALUControl, 4'h6);
    chk("stall.hold_valid", outValid, 1);
    x.flush = 1;
    cyc("stall_flush", x);
    chk("stall_flush.valid", outValid, 0);
    chk("stall_flush.rw", regWrite, 0);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] ops[9] = '{6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h3f};
      logic [5:0] fns[9] = '{6'h20, 6'h22, 6'h27, 6'h00, 6'h02, 6'h24, 6'h25, 6'h2a, 6'h3f};
      x = mk(ops[$urandom_range(0, 8)], fns[$urandom_range(0, 8)], 5'($urandom),
             16'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom);
      x = fw(x, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      x.iv = ($urandom_range(0, 4) != 0);
      x.stall = ($urandom_range(0, 5) == 0);
      x.flush = ($urandom_range(0, 9) == 0);
      cyc($sformatf("rnd%0d", i), x);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
